rom_loader: RTL and testbench
=============================

# rom_loader

Upstream feeder for the two-half mean stage. On a `go` request it streams DEPTH bytes out of a synchronous ROM into an internal register buffer and presents that buffer as the mean stage's parallel `rom_in` bus. It then issues a single-cycle `start` once the stage reports `ready`, waits for `done`, and holds the returned `mean` as a registered result with a valid flag.

## Interface
Parameters:
- DEPTH, 32, number of bytes fetched and presented; must equal the mean stage's input array size.
- AW, 5, ROM address width; 2**AW >= DEPTH.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- go  input  1  request a fetch-and-compute run; sampled only in IDLE.
- rom_en  output  1  ROM read enable.
- rom_addr  output  AW  ROM read address.
- rom_data  input  8  ROM read data; valid on the cycle after the edge that sampled `rom_en` and `rom_addr` (1-cycle latency).
- data_out  output  8 x DEPTH (unpacked [0:DEPTH-1])  buffered bytes; drives the mean stage's `rom_in`.
- start  output  1  single-cycle launch pulse to the mean stage.
- ready  input  1  mean stage can accept `start`.
- done  input  1  mean stage has finished.
- mean  input  8  mean stage result; valid while `done`=1.
- result  output  8  captured mean.
- result_valid  output  1  `result` holds the value from the last completed run.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, FETCH, DRAIN, LAUNCH, WAIT_DONE.
- IDLE: `go`=1 -> FETCH. On the same edge: `rom_en`<=1, `rom_addr`<=0, `result_valid`<=0.
- FETCH: each edge increments `rom_addr`. The edge on which the data for address k is present writes `rom_data` into `data_out[k]`. After address DEPTH-1 has been issued: `rom_en`<=0 -> DRAIN.
- DRAIN: capture the final byte into `data_out[DEPTH-1]` -> LAUNCH.
- LAUNCH: on an edge with `ready`=1: `start`<=1 -> WAIT_DONE. If `ready`=0, stay in LAUNCH indefinitely with `start`=0.
- WAIT_DONE: `start`<=0 on the first edge. `done` is ignored while `start`=1 and is sampled from the following edge onward. On `done`=1: `result`<=`mean`, `result_valid`<=1 -> IDLE.
- `go` outside IDLE is ignored; no queuing.
- `data_out` is stable from DRAIN exit until the next run's FETCH writes. Each byte changes only on its own write edge.
- `result` / `result_valid` hold until the next accepted `go`, which clears `result_valid` only; `result` keeps its old value.
- Widths: the address counter is AW bits and never wraps within a run; the byte index equals the address.

## Timing
- Reset values: state IDLE; `rom_en`=0, `rom_addr`=0, `start`=0, `result`=0, `result_valid`=0, `busy`=0; all `data_out[k]`=0.
- `rst` mid-run (any state) aborts on that edge: every output and register returns to its reset value, and no `start` is issued afterwards.
- With `go` sampled at edge E0:
  - `rom_addr`=k during the cycle after E(k); `rom_en`=1 from E0 to E(DEPTH).
  - `data_out[k]` is written at E(k+2).
  - Last byte at E(DEPTH+1), which is DRAIN's edge.
  - LAUNCH at E(DEPTH+1); with `ready`=1, `start` is high from E(DEPTH+2) to E(DEPTH+3).
  - For DEPTH=32: `start` is high in the cycle after E34, earliest.
- `busy` rises at E0 and falls on the edge that captures `result`.
- `start` is never high for more than one cycle per run.

## Test plan
- ROM[k]=k, DEPTH=32, `ready`=1, downstream stub asserts `done` with `mean`=15, 4 cycles after `start` -> `data_out[k]`=k for all k; `start` high only in the cycle after E34; `result`=15; `result_valid`=1; `busy`=0 after capture.
- `ready` held 0 for 10 cycles after DRAIN -> `start` stays 0, `busy`=1; `start` pulses exactly once on the edge after `ready` rises.
- `done` held 1 from a previous run while `start` pulses -> ignored during the `start` cycle; `result` captured only on the first `done`=1 at a later edge.
- `rst` asserted at E10 of FETCH -> all outputs at reset values on the next cycle, `data_out[0..7]` cleared to 0; a later `go` completes normally.
- `go` pulsed during FETCH and during WAIT_DONE -> ignored; exactly one run occurs.
- Back-to-back runs: ROM refilled with 0xAA, `go` issued in the cycle after `result_valid` rises -> `result_valid` falls at the accepted `go`; buffer becomes all 0xAA; second `result` equals the stub's `mean` (0xAA).

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader
//
// Upstream feeder for the two-half mean stage. A `go` request streams DEPTH
// bytes out of a synchronous ROM (1-cycle read latency) into a register buffer
// that is presented in parallel on `data_out`. Once the whole buffer is loaded
// it launches the mean stage with a single-cycle `start` (waiting on `ready`),
// then waits for `done` and keeps the returned `mean` as a registered result.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset, aborts any run
//   go            run request, only honoured while idle
//   rom_en        ROM read enable
//   rom_addr      ROM read address (AW bits)
//   rom_data      ROM read data, valid the cycle after the sampling edge
//   data_out      buffered bytes, drives the mean stage's rom_in bus
//   start         one-cycle launch pulse to the mean stage
//   ready         mean stage can accept start
//   done          mean stage has finished
//   mean          mean stage result, valid while done is high
//   result        captured mean
//   result_valid  result holds the value of the last completed run
//   busy          high whenever a run is in progress

module rom_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    output logic [7:0]    data_out [0:DEPTH-1],
    output logic          start,
    input  logic          ready,
    input  logic          done,
    input  logic [7:0]    mean,
    output logic [7:0]    result,
    output logic          result_valid,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        LAUNCH,
        WAIT_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_next;

    logic          fetch_begin;
    logic          fetch_last;
    logic          launch;
    logic          capture;

    logic          cap_pending;
    logic [AW-1:0] cap_idx;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the one-edge control strobes used by the
    // datapath registers below.
    always_comb begin
        state_next  = state;
        fetch_begin = 1'b0;
        fetch_last  = 1'b0;
        launch      = 1'b0;
        capture     = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    state_next  = FETCH;
                    fetch_begin = 1'b1;
                end
            end
            FETCH: begin
                // The last address is being sampled by the ROM on this edge,
                // so the read enable can drop now.
                if (rom_addr == LAST_ADDR) begin
                    state_next = DRAIN;
                    fetch_last = 1'b1;
                end
            end
            DRAIN: begin
                state_next = LAUNCH;
            end
            LAUNCH: begin
                if (ready) begin
                    state_next = WAIT_DONE;
                    launch     = 1'b1;
                end
            end
            WAIT_DONE: begin
                // While start is still high, done may be a leftover from the
                // previous run, so it is only trusted from the next edge on.
                if (!start && done) begin
                    state_next = IDLE;
                    capture    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ROM address generator: one address per edge while fetching.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_en   <= 1'b0;
            rom_addr <= '0;
        end else if (fetch_begin) begin
            rom_en   <= 1'b1;
            rom_addr <= '0;
        end else if (fetch_last) begin
            rom_en   <= 1'b0;
        end else if (state == FETCH) begin
            rom_addr <= rom_addr + 1'b1;
        end
    end

    // Remember which address the ROM sampled on this edge so the returning
    // byte can be steered into the right slot one edge later. This also
    // covers the final byte, which arrives while already in DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_pending <= 1'b0;
            cap_idx     <= '0;
        end else begin
            cap_pending <= rom_en;
            cap_idx     <= rom_addr;
        end
    end

    // Byte buffer: each slot changes only on its own write edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_out[k] <= '0;
            end
        end else if (cap_pending) begin
            data_out[cap_idx] <= rom_data;
        end
    end

    // Launch pulse and result capture. A new accepted go only clears the
    // valid flag; the old result value stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            start        <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            start <= launch;
            if (fetch_begin) begin
                result_valid <= 1'b0;
            end
            if (capture) begin
                result       <= mean;
                result_valid <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader
//
// Bench for rom_loader. Surrounds the loader with a behavioural synchronous
// ROM and a mean-stage stub, then runs directed and randomized runs. The
// expected behaviour is derived from the run's timeline: with go sampled at
// edge E0, address k is on the bus after E(k), byte k lands at E(k+2), start
// is high after E(DEPTH+2+ready_delay), and the result appears one edge after
// the stub raises done.

module tb_rom_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go = 1'b0;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data = 8'h00;
    logic [7:0]    data_out [0:DEPTH-1];
    logic          start;
    logic          ready = 1'b0;
    logic          done = 1'b0;
    logic [7:0]    mean = 8'h00;
    logic [7:0]    result;
    logic          result_valid;
    logic          busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state kept by the bench.
    logic [7:0] rom     [0:DEPTH-1];
    logic [7:0] exp_buf [0:DEPTH-1];
    logic [7:0] exp_result = 8'h00;
    logic       exp_valid  = 1'b0;

    // Mean-stage stub controls.
    int         stub_delay  = 1;
    bit         stub_sticky = 1'b0;
    logic [7:0] stub_mean   = 8'h00;
    int         stub_cnt    = 0;

    rom_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .rom_en       (rom_en),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .data_out     (data_out),
        .start        (start),
        .ready        (ready),
        .done         (done),
        .mean         (mean),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) begin
        if (rom_en) begin
            rom_data <= rom[rom_addr];
        end
    end

    // Mean-stage stub: raises done stub_delay cycles after it sees start and
    // holds it until the next start. In sticky mode the old done stays high
    // through the start cycle itself.
    always @(negedge clk) begin
        if (rst) begin
            done     = 1'b0;
            mean     = 8'h00;
            stub_cnt = 0;
        end else if (start) begin
            stub_cnt = stub_delay;
            if (!stub_sticky) begin
                done = 1'b0;
            end
        end else if (stub_cnt > 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) begin
                done = 1'b1;
                mean = stub_mean;
            end else begin
                done = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Idle cycles: nothing may start, and the last result must hold.
    task automatic idleCheck(input int cycles, input string tag);
        int bad;
        bad = 0;
        go  = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || start !== 1'b0 || rom_en !== 1'b0) bad++;
            if (result_valid !== exp_valid || result !== exp_result) bad++;
        end
        checkOutput(tag, bad, 0);
    endtask

    // One complete run. Entered and left at a negedge; the go issued here is
    // sampled by the very next rising edge (E0).
    task automatic applyStimulus(input int rdel, input int ddel, input bit sticky,
                                 input bit noise, input logic [7:0] mval);
        int         s_idx, f_idx, starts, first_start;
        int         bad_addr, bad_buf, bad_busy, bad_res;
        logic [7:0] old_buf [0:DEPTH-1];
        logic [7:0] old_result;
        logic [7:0] want;

        s_idx       = DEPTH + 2 + rdel;
        f_idx       = s_idx + ddel + 1;
        old_buf     = exp_buf;
        old_result  = exp_result;
        stub_delay  = ddel;
        stub_sticky = sticky;
        stub_mean   = mval;
        starts      = 0;
        first_start = -1;
        bad_addr    = 0;
        bad_buf     = 0;
        bad_busy    = 0;
        bad_res     = 0;

        ready = 1'b0;
        go    = 1'b1;
        for (int i = 0; i <= f_idx; i++) begin
            @(negedge clk);
            if (i == 0) go = 1'b0;

            if (i < DEPTH) begin
                if (rom_en !== 1'b1 || rom_addr !== AW'(i)) bad_addr++;
            end else if (rom_en !== 1'b0) begin
                bad_addr++;
            end

            for (int k = 0; k < DEPTH; k++) begin
                want = (k <= i - 2) ? rom[k] : old_buf[k];
                if (data_out[k] !== want) bad_buf++;
            end

            if (start === 1'b1) begin
                starts++;
                if (first_start < 0) first_start = i;
            end

            if (i < f_idx) begin
                if (busy !== 1'b1) bad_busy++;
                if (result_valid !== 1'b0 || result !== old_result) bad_res++;
            end

            // Drive inputs for the next edge.
            ready = (i >= DEPTH + 1 + rdel);
            if (noise && (i == 5 || i == s_idx)) go = 1'b1;
            if (noise && (i == 6 || i == s_idx + 1)) go = 1'b0;
        end

        checkOutput("addr_sequence", bad_addr, 0);
        checkOutput("buffer_progress", bad_buf, 0);
        checkOutput("busy_during_run", bad_busy, 0);
        checkOutput("result_hold", bad_res, 0);
        checkOutput("start_count", starts, 1);
        checkOutput("start_cycle", first_start, s_idx);
        checkOutput("result", result, mval);
        checkOutput("result_valid", result_valid, 1);
        checkOutput("busy_after", busy, 0);
        for (int k = 0; k < DEPTH; k++) begin
            checkOutput($sformatf("data_out[%0d]", k), data_out[k], rom[k]);
        end

        exp_buf    = rom;
        exp_result = mval;
        exp_valid  = 1'b1;
    endtask

    // Abort a run with reset on E10 of the fetch.
    task automatic resetMidFetch();
        int bad;
        bad = 0;
        go  = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int i = 1; i <= 9; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_rom_en", rom_en, 0);
        checkOutput("rst_rom_addr", rom_addr, 0);
        checkOutput("rst_start", start, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_result_valid", result_valid, 0);
        checkOutput("rst_busy", busy, 0);
        for (int k = 0; k < DEPTH; k++) begin
            if (data_out[k] !== 8'h00) bad++;
        end
        checkOutput("rst_buffer_cleared", bad, 0);
        for (int k = 0; k < DEPTH; k++) exp_buf[k] = 8'h00;
        exp_result = 8'h00;
        exp_valid  = 1'b0;
    endtask

    initial begin
        int bad;
        for (int k = 0; k < DEPTH; k++) begin
            rom[k]     = 8'h00;
            exp_buf[k] = 8'h00;
        end

        // Power-on reset.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_rom_en", rom_en, 0);
        checkOutput("reset_rom_addr", rom_addr, 0);
        checkOutput("reset_start", start, 0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_result_valid", result_valid, 0);
        checkOutput("reset_busy", busy, 0);
        bad = 0;
        for (int k = 0; k < DEPTH; k++) if (data_out[k] !== 8'h00) bad++;
        checkOutput("reset_buffer", bad, 0);
        rst = 1'b0;
        idleCheck(2, "idle_after_reset");

        // Counting ROM, ready high, done four cycles after start, mean 15.
        for (int k = 0; k < DEPTH; k++) rom[k] = 8'(k);
        applyStimulus(0, 4, 1'b0, 1'b0, 8'd15);
        idleCheck(3, "idle_after_first");

        // Ready held low for 10 cycles; stale done held through start.
        for (int k = 0; k < DEPTH; k++) rom[k] = 8'($urandom);
        applyStimulus(10, 3, 1'b1, 1'b0, 8'h5C);
        idleCheck(2, "idle_after_ready_wait");

        // Stray go pulses in FETCH and WAIT_DONE must not queue a run.
        for (int k = 0; k < DEPTH; k++) rom[k] = 8'($urandom);
        applyStimulus(2, 5, 1'b0, 1'b1, 8'h3E);
        idleCheck(40, "no_extra_run");

        // Reset in the middle of the fetch, then a normal run.
        for (int k = 0; k < DEPTH; k++) rom[k] = 8'(k + 1);
        resetMidFetch();
        idleCheck(45, "no_start_after_abort");
        for (int k = 0; k < DEPTH; k++) rom[k] = 8'($urandom);
        applyStimulus(1, 2, 1'b1, 1'b0, 8'h71);

        // Back-to-back: go in the cycle result_valid rises, ROM now all 0xAA.
        for (int k = 0; k < DEPTH; k++) rom[k] = 8'hAA;
        applyStimulus(0, 1, 1'b1, 1'b0, 8'hAA);
        idleCheck(2, "idle_after_back_to_back");

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < DEPTH; k++) rom[k] = 8'($urandom);
            applyStimulus(int'($urandom_range(0, 12)), int'($urandom_range(1, 6)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom));
            idleCheck(int'($urandom_range(1, 4)), "idle_random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
